// File: rtl/rom_reader.sv
// rom_reader: reads a burst of consecutive ROM words and streams them out
// over a valid/ready port.
//
// A read is issued only while the words held in the 2-entry output FIFO,
// plus the read still in flight, minus the word leaving this cycle, is
// below two. This keeps the FIFO from overflowing and still gives one word
// per cycle when out_ready stays high.
//
// Handshake: a word moves downstream on every rising clock edge where
// out_valid and out_ready are both 1. Once raised, out_valid and out_data
// stay put until that happens. out_ready may change on any cycle.
//
// Optional build: define ROM_READER_CHECKSUM_EN to add the csum output,
// the XOR of every word transferred in the current burst.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 FETCH, 2 DRAIN, 3 DONE.
module rom_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len_m1,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
`ifdef ROM_READER_CHECKSUM_EN
  output logic [DATA_W-1:0] csum,
`endif
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // One extra bit so a full 2^ADDR_W-word burst can be counted.
  localparam int CW = ADDR_W + 1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [CW-1:0]     issued_cnt;
  logic [CW-1:0]     xfer_cnt;
  logic [CW-1:0]     len_ext;
  logic              inflight_q;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;
  logic              push;
  logic              pop;
  logic [2:0]        level;

  assign len_ext   = {1'b0, len_q};
  assign push      = inflight_q;
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid & out_ready;

  // Occupancy the FIFO would have next cycle if no new read were issued.
  assign level  = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign rom_en = (state == S_FETCH) && (level < 3'd2);

  // Show the new address only while reading; otherwise keep the last one.
  assign rom_addr = rom_en ? next_addr : last_addr;

  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (xfer_cnt == len_ext);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  // Burst control: state, address generation and the read/transfer counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      len_q      <= '0;
      next_addr  <= '0;
      last_addr  <= '0;
      issued_cnt <= '0;
      xfer_cnt   <= '0;
    end else begin
      if (pop) begin
        xfer_cnt <= xfer_cnt + CW'(1);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= len_m1;
            next_addr  <= base_addr;
            issued_cnt <= '0;
            xfer_cnt   <= '0;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rom_en) begin
            next_addr  <= next_addr + ADDR_W'(1);
            last_addr  <= next_addr;
            issued_cnt <= issued_cnt + CW'(1);
            if (issued_cnt == len_ext) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (pop && out_last) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A read issued this cycle returns its data next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rom_en;
    end
  end

  // Two-entry output FIFO; the returning ROM word is pushed unconditionally.
  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rom_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  // Running XOR of transferred words; holds after done until the next start.
  always_ff @(posedge clock) begin
    if (reset) begin
      csum <= '0;
    end else if (state == S_IDLE && start) begin
      csum <= '0;
    end else if (pop) begin
      csum <= csum ^ out_data;
    end
  end
`endif

endmodule
